// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl
//   Front-end controller for a single-port RW SRAM macro (1-cycle read
//   latency, lane-masked write). An independent read-request stream and
//   write-request stream share the one macro port. Read data is captured
//   into a 2-entry response FIFO with valid/ready backpressure.
//
//   Writes win arbitration by default. A waiting read is forced through
//   after WR_STREAK consecutive write grants, provided it has FIFO credit.
//
// Optional feature (compile-time macro SRAM_INIT_CLEAR_EN):
//   When defined, the controller sweeps every address once after reset,
//   writing zero with all lanes enabled, before accepting traffic.
//   When undefined, the controller runs from the first cycle out of reset.
//
// Ports
//   clock, reset                      sole clock; synchronous active-high reset
//   rd_req_valid/ready/addr           read request handshake
//   wr_req_valid/ready/addr/mask/data write request handshake
//   rsp_valid/ready/data              read response (FIFO head)
//   init_done                         controller accepts traffic
//   RW0_addr/en/wmode/wmask/wdata     macro command, driven the grant cycle
//   RW0_rdata                         macro read data, valid the cycle after a read
module sram_rw_port_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 128,
  parameter int MASK_W    = 16,
  parameter int WR_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [MASK_W-1:0] wr_req_mask,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int STREAK_W = 4;

  logic              run;
  logic              init_active;
  logic [ADDR_W-1:0] init_addr;

`ifdef SRAM_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == '1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign run         = !reset && (state_q == ST_RUN);
  assign init_active = !reset && (state_q == ST_INIT);
  assign init_addr   = init_addr_q;
  assign init_done   = run;
`else
  assign run         = !reset;
  assign init_active = 1'b0;
  assign init_addr   = '0;
  assign init_done   = !reset;
`endif

  // Control state
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                wptr_q, rptr_q;
  logic                rd_vld_p1_q;
  logic [DATA_W-1:0]   fifo_q [2];

  logic       deq, enq, credit, streak_hit, rd_grant, wr_grant;
  logic [2:0] load, limit;

  assign rsp_valid = !reset && (cnt_q != 2'd0);
  assign rsp_data  = rsp_valid ? fifo_q[rptr_q] : '0;
  assign deq       = rsp_valid && rsp_ready;
  assign enq       = rd_vld_p1_q;

  // A read needs a FIFO slot for itself once everything already queued or
  // in flight is counted, net of the entry leaving this cycle.
  assign load   = {1'b0, cnt_q} + {2'b00, rd_vld_p1_q};
  assign limit  = 3'd2 + {2'b00, deq};
  assign credit = load < limit;

  assign streak_hit   = (streak_q == STREAK_W'(WR_STREAK));
  assign rd_req_ready = run && credit && (!wr_req_valid || streak_hit);
  assign rd_grant     = rd_req_ready && rd_req_valid;
  assign wr_req_ready = run && !rd_grant;
  assign wr_grant     = wr_req_ready && wr_req_valid;

  always_comb begin
    streak_d = streak_q;
    if (!rd_req_valid || rd_grant) begin
      streak_d = '0;
    end else if (wr_grant && !streak_hit) begin
      // Saturate: a starved read that lacks credit must not wrap the count.
      streak_d = streak_q + 1'b1;
    end
  end

  assign cnt_d = cnt_q + {1'b0, enq} - {1'b0, deq};

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = rd_req_addr;
    RW0_wmask = '0;
    RW0_wdata = wr_req_data;
    if (init_active) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = init_addr;
      RW0_wmask = '1;
      RW0_wdata = '0;
    end else if (wr_grant) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = wr_req_addr;
      RW0_wmask = wr_req_mask;
    end else if (rd_grant) begin
      RW0_en    = 1'b1;
    end
  end

  // Stage p0 -> p1: read issued to macro; p1 -> FIFO: macro data captured
  always_ff @(posedge clock) begin
    if (reset) begin
      streak_q    <= '0;
      cnt_q       <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      rd_vld_p1_q <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_q ^ enq;
      rptr_q      <= rptr_q ^ deq;
      rd_vld_p1_q <= rd_grant;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) fifo_q[wptr_q] <= RW0_rdata;
  end

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
module tb_sram_rw_port_ctrl;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 128;
  localparam int MASK_W    = 16;
  localparam int WR_STREAK = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              wr_req_valid, wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [MASK_W-1:0] wr_req_mask;
  logic [DATA_W-1:0] wr_req_data;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              init_done;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en, RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  sram_rw_port_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .WR_STREAK(WR_STREAK)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_mask(wr_req_mask), .wr_req_data(wr_req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Macro model: 1-cycle registered read, lane-masked write
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];

  function automatic logic [DATA_W-1:0] apply_mask(input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = old;
    for (int l = 0; l < MASK_W; l++) if (m[l]) r[l*8 +: 8] = d[l*8 +: 8];
    return r;
  endfunction

  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] = apply_mask(mem[RW0_addr], RW0_wdata, RW0_wmask);
      else RW0_rdata <= mem[RW0_addr];
    end
  end

  // Scoreboard: expected read data captured at issue, compared at dequeue
  logic [DATA_W-1:0] exp_q [$];

  always @(negedge clock) begin
    if (!reset) begin
      if (wr_req_valid && wr_req_ready) begin
        chk("wr_issue_cmd", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask},
            {1'b1, 1'b1, wr_req_addr, wr_req_mask});
        shadow[wr_req_addr] = apply_mask(shadow[wr_req_addr], wr_req_data, wr_req_mask);
      end
      if (rd_req_valid && rd_req_ready) begin
        chk("rd_issue_cmd", {RW0_en, RW0_wmode, RW0_addr}, {1'b1, 1'b0, rd_req_addr});
        exp_q.push_back(shadow[rd_req_addr]);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL rsp_spurious: got data %h with no outstanding read", rsp_data);
        end else begin
          chk("rsp_data", rsp_data, exp_q.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic              wv;
    logic [ADDR_W-1:0] wa;
    logic [MASK_W-1:0] wm;
    logic [DATA_W-1:0] wd;
    logic              rv;
    logic [ADDR_W-1:0] ra;
    logic              exp_wr;
    logic              exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic [ADDR_W-1:0] wa,
      input logic [MASK_W-1:0] wm, input logic [DATA_W-1:0] wd,
      input logic rv, input logic [ADDR_W-1:0] ra, input logic ew, input logic er);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wm = wm; v.wd = wd;
    v.rv = rv; v.ra = ra; v.exp_wr = ew; v.exp_rd = er;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input vec_t v, input string nm);
    wr_req_valid = v.wv; wr_req_addr = v.wa; wr_req_mask = v.wm; wr_req_data = v.wd;
    rd_req_valid = v.rv; rd_req_addr = v.ra;
    @(negedge clock);
    chk({nm, "_wr_ready"}, wr_req_ready, v.exp_wr);
    chk({nm, "_rd_ready"}, rd_req_ready, v.exp_rd);
    cyc();
  endtask

  task automatic idle(input int n);
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Called right after reset deasserts; returns one cycle after traffic is allowed.
  task automatic after_reset();
`ifdef SRAM_INIT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      chk($sformatf("init_sweep%0d", i),
          {init_done, RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata[7:0]},
          {1'b0, 1'b1, 1'b1, ADDR_W'(i), {MASK_W{1'b1}}, 8'h00});
      chk($sformatf("init_wdata%0d", i), RW0_wdata, '0);
    end
    @(negedge clock);
    chk("init_done_after_sweep", init_done, 1'b1);
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
`else
    @(negedge clock);
    chk("init_done_after_reset", init_done, 1'b1);
`endif
    cyc();
  endtask

  vec_t tbl [10];
  logic [DATA_W-1:0] a5, d5a, dc3, dff;
  logic [15:0] pat;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    a5  = {16{8'hA5}};
    d5a = {16{8'h5A}};
    dc3 = {16{8'hC3}};
    dff = '1;
    tbl[0] = mk(1'b1, 4'd5, 16'hFFFF, a5,  1'b0, 4'd0, 1'b1, 1'b0);
    tbl[1] = mk(1'b0, 4'd0, 16'h0000, '0,  1'b1, 4'd5, 1'b0, 1'b1);
    tbl[2] = mk(1'b0, 4'd0, 16'h0000, '0,  1'b1, 4'd7, 1'b0, 1'b1);
    tbl[3] = mk(1'b1, 4'd7, 16'hFFFF, d5a, 1'b0, 4'd0, 1'b1, 1'b0);
    tbl[4] = mk(1'b1, 4'd3, 16'h00FF, dff, 1'b0, 4'd0, 1'b1, 1'b0);
    tbl[5] = mk(1'b0, 4'd0, 16'h0000, '0,  1'b1, 4'd3, 1'b0, 1'b1);
    tbl[6] = mk(1'b0, 4'd0, 16'h0000, '0,  1'b0, 4'd0, 1'b1, 1'b1);
    tbl[7] = mk(1'b1, 4'd9, 16'hFFFF, dc3, 1'b1, 4'd9, 1'b1, 1'b0);
    tbl[8] = mk(1'b0, 4'd0, 16'h0000, '0,  1'b1, 4'd9, 1'b0, 1'b1);
    tbl[9] = mk(1'b0, 4'd0, 16'h0000, '0,  1'b0, 4'd0, 1'b1, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      pat = 16'h1000 + 16'(i);
      mem[i]    = {8{pat}};
      shadow[i] = {8{pat}};
    end

    // Reset state, with both requests asserted to show readies stay low
    reset = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = '0;
    wr_req_valid = 1'b1; wr_req_addr = '0; wr_req_mask = '1; wr_req_data = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_rd_ready", rd_req_ready, 1'b0);
    chk("reset_wr_ready", wr_req_ready, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_rw0_en", {RW0_en, RW0_wmode}, 2'b00);
    chk("reset_init_done", init_done, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    after_reset();

    // Table: write-then-read, read-then-write hazard, partial mask, arbitration
    for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("vec%0d", i));
    idle(3);

    // Read latency: issue N, rsp_valid low in N+1, high in N+2
    rd_req_valid = 1'b1; rd_req_addr = 4'd5;
    @(negedge clock);
    chk("lat_issue_ready", rd_req_ready, 1'b1);
    chk("lat_n0_rsp_valid", rsp_valid, 1'b0);
    cyc();
    rd_req_valid = 1'b0;
    @(negedge clock);
    chk("lat_n1_rsp_valid", rsp_valid, 1'b0);
    cyc();
    @(negedge clock);
    chk("lat_n2_rsp_valid", rsp_valid, 1'b1);
    chk("lat_n2_rsp_data", rsp_data, a5);
    cyc();
    idle(2);

    // Write streak: both valid continuously -> 4 writes then 1 read
    for (int k = 0; k < 15; k++)
      step(mk(1'b1, ADDR_W'(k), 16'(($urandom() & 32'hFFFF) | 32'h1),
              {$urandom(), $urandom(), $urandom(), $urandom()},
              1'b1, 4'd2, (k % 5) != 4, (k % 5) == 4),
           $sformatf("streak%0d", k));
    idle(4);
    chk("streak_drained", 32'(exp_q.size()), 0);

    // Backpressure: two reads fill the FIFO, the third stalls, writes continue
    rsp_ready = 1'b0;
    step(mk(1'b0, 4'd0, '0, '0, 1'b1, 4'd1, 1'b0, 1'b1), "bp_rd1");
    step(mk(1'b0, 4'd0, '0, '0, 1'b1, 4'd2, 1'b0, 1'b1), "bp_rd2");
    step(mk(1'b0, 4'd0, '0, '0, 1'b1, 4'd3, 1'b1, 1'b0), "bp_rd3_stall");
    step(mk(1'b1, 4'd4, 16'hFFFF, d5a, 1'b1, 4'd3, 1'b1, 1'b0), "bp_wr_during_stall");
    chk("bp_rsp_valid_held", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    step(mk(1'b0, 4'd0, '0, '0, 1'b1, 4'd3, 1'b0, 1'b1), "bp_rd3_accept");
    idle(5);
    chk("bp_drained", 32'(exp_q.size()), 0);

    // Reset with one read queued and one in flight
    rsp_ready = 1'b0;
    step(mk(1'b0, 4'd0, '0, '0, 1'b1, 4'd6, 1'b0, 1'b1), "rst_rd1");
    step(mk(1'b0, 4'd0, '0, '0, 1'b1, 4'd8, 1'b0, 1'b1), "rst_rd2");
    reset = 1'b1;
    exp_q.delete();
    rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    @(negedge clock);
    chk("midrst_rd_ready", rd_req_ready, 1'b0);
    chk("midrst_wr_ready", wr_req_ready, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    rsp_ready = 1'b1;
    after_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("postrst_rsp_valid%0d", i), rsp_valid, 1'b0);
      cyc();
    end

    // Traffic still flows after the mid-operation reset
    step(mk(1'b0, 4'd0, '0, '0, 1'b1, 4'd5, 1'b0, 1'b1), "postrst_rd");
    idle(4);
    chk("postrst_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
